shot_seq_ctrl: RTL

- Sequencer for the per-microphone slope_det channels. It latches and distributes the slope threshold and polarity, and arms detection after a pipeline-flush settle period.
- Starts a shared timebase on the first channel's det and timestamps the first det rising edge of every channel. Ends on all-hit or timeout, then holds results for the host and enforces a hold-off before re-arming.
- Sits in the clk8M domain between the slope_det array and the host register interface.

---
 rtl/shot_pkg.sv | 24 ++
 rtl/edge_capture.sv | 52 +++++
 rtl/shot_seq_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/shot_pkg.sv
// Shared state encoding and clk8M-derived timing constants for the shot sequencer.
package shot_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StArming  = 3'd1,
        StWait    = 3'd2,
        StCapture = 3'd3,
        StDone    = 3'd4,
        StHoldoff = 3'd5
    } state_t;

    localparam int unsigned NCH_DEF       = 4;
    localparam int unsigned CW_DEF        = 16;
    localparam int unsigned CLK_HZ        = 8_000_000;
    localparam int unsigned TMO_1MS       = CLK_HZ / 1000;
    localparam int unsigned HOLDOFF_500US = CLK_HZ / 2000;
    localparam int unsigned SETTLE_LPF    = 8;

    function automatic logic is_busy(state_t s);
        return (s == StArming) || (s == StWait) || (s == StCapture);
    endfunction

endpackage

// File: rtl/edge_capture.sv
// One slope_det channel: det history, rising-edge detect and first-hit timestamp latch.
module edge_capture #(
    parameter int unsigned CW = 16
) (
    input  logic          clk8M,
    input  logic          reset_n,
    input  logic          det,
    input  logic [CW-1:0] cnt,
    input  logic          capture_en,
    input  logic          clear,
    input  logic          clear_hit,
    output logic          hit,
    output logic          new_hit,
    output logic [CW-1:0] ts
);

    logic          det_q;
    logic          hit_q, hit_d;
    logic [CW-1:0] ts_q, ts_d;

    always_comb begin
        // Only the first rising edge after arming is kept.
        new_hit = capture_en & det & ~det_q & ~hit_q;
        hit_d   = hit_q;
        ts_d    = ts_q;
        if (clear) begin
            hit_d = 1'b0;
            ts_d  = '0;
        end else if (clear_hit) begin
            hit_d = 1'b0;
        end else if (new_hit) begin
            hit_d = 1'b1;
            ts_d  = cnt;
        end
    end

    always_ff @(posedge clk8M or negedge reset_n) begin
        if (!reset_n) begin
            det_q <= 1'b0;
            hit_q <= 1'b0;
            ts_q  <= '0;
        end else begin
            det_q <= det;
            hit_q <= hit_d;
            ts_q  <= ts_d;
        end
    end

    assign hit = hit_q;
    assign ts  = ts_q;

endmodule

// File: rtl/shot_seq_ctrl.sv
// Shot sequencer: latches slope config, arms the slope_det array, timestamps the
// first edge per channel against a shared timebase and hands results to the host.
module shot_seq_ctrl
    import shot_pkg::*;
#(
    parameter int unsigned   NCH     = NCH_DEF,
    parameter int unsigned   CW      = CW_DEF,
    parameter logic [CW-1:0] TMO     = CW'(TMO_1MS),
    parameter int unsigned   SETTLE  = SETTLE_LPF,
    parameter int unsigned   HOLDOFF = HOLDOFF_500US
) (
    input  logic              clk8M,
    input  logic              reset_n,
    input  logic              arm,
    input  logic              abort,
    input  logic              ack,
    input  logic [5:0]        slope_cfg,
    input  logic              slope_neg_cfg,
    input  logic [NCH-1:0]    det,
    output logic [5:0]        slope,
    output logic              slope_neg,
    output logic [NCH*CW-1:0] ts,
    output logic [NCH-1:0]    hit,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [2:0]        state
);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    slope_q, slope_d;
    logic          slope_neg_q, slope_neg_d;
    logic          timeout_q, timeout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic           capture_en, clear, clear_hit;
    logic [NCH-1:0] new_hit;
    logic           all_hit, any_new;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        edge_capture #(
            .CW(CW)
        ) u_cap (
            .clk8M      (clk8M),
            .reset_n    (reset_n),
            .det        (det[i]),
            .cnt        (cnt_q),
            .capture_en (capture_en),
            .clear      (clear),
            .clear_hit  (clear_hit),
            .hit        (hit[i]),
            .new_hit    (new_hit[i]),
            .ts         (ts[i*CW +: CW])
        );
    end

    assign all_hit = &(hit | new_hit);
    assign any_new = |new_hit;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        slope_d     = slope_q;
        slope_neg_d = slope_neg_q;
        timeout_d   = timeout_q;
        capture_en  = 1'b0;
        clear       = 1'b0;
        clear_hit   = 1'b0;

        if (abort) begin
            state_d   = StIdle;
            cnt_d     = '0;
            timeout_d = 1'b0;
            clear_hit = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arm) begin
                        slope_d     = slope_cfg;
                        slope_neg_d = slope_neg_cfg;
                        timeout_d   = 1'b0;
                        cnt_d       = '0;
                        clear       = 1'b1;
                        state_d     = StArming;
                    end
                end
                StArming: begin
                    if (cnt_q == CW'(SETTLE - 1)) begin
                        cnt_d   = '0;
                        state_d = StWait;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StWait: begin
                    // cnt is 0 here, so the opening edges are stamped 0.
                    capture_en = 1'b1;
                    if (any_new) begin
                        cnt_d     = CW'(1);
                        timeout_d = 1'b0;
                        state_d   = all_hit ? StDone : StCapture;
                    end
                end
                StCapture: begin
                    capture_en = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    if (all_hit) begin
                        timeout_d = 1'b0;
                        state_d   = StDone;
                    end else if (cnt_q == TMO) begin
                        timeout_d = 1'b1;
                        state_d   = StDone;
                    end
                end
                StDone: begin
                    if (ack) begin
                        cnt_d   = '0;
                        state_d = StHoldoff;
                    end
                end
                StHoldoff: begin
                    if (cnt_q == CW'(HOLDOFF - 1)) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            endcase
        end

        busy_d = is_busy(state_d);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk8M or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            slope_q     <= '0;
            slope_neg_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            slope_q     <= slope_d;
            slope_neg_q <= slope_neg_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign slope     = slope_q;
    assign slope_neg = slope_neg_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state     = state_q;

endmodule
